control_unit: RTL and testbench



---
 rtl/control_unit.sv | 143 ++++++++++++++
 tb/tb_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Dual-lane RV32 decoder: per-lane ALU/branch controls plus a mode-dependent shared ALU fine-control word.
// Latency: decode outputs are combinational (zero cycles); IllegalSeen is a sticky flag set on clk.
// Backpressure: none; outputs always track the inputs.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcodeA,
  input  logic [6:0] opcodeB,
  input  logic [2:0] funct3A,
  input  logic [2:0] funct3B,
  input  logic [6:0] funct7A,
  input  logic [6:0] funct7B,
  input  logic       mode,
  output logic [2:0] ALUOpA,
  output logic [2:0] ALUOpB,
  output logic [5:0] ALUCtrl,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       MemWriteA,
  output logic       MemWriteB,
  output logic       BranchA,
  output logic       BranchB,
  output logic [2:0] BranchTypeA,
  output logic [2:0] BranchTypeB,
  output logic       IllegalSeen
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       memwrite;
    logic       branch;
    logic [2:0] btype;
    logic [1:0] shf;      // {right, arith}
    logic       illegal;
  } dec_t;

  function automatic logic [2:0] alu_class(input logic [2:0] f3);
    logic [2:0] c;
    case (f3)
      3'b000:  c = 3'b000;
      3'b111:  c = 3'b001;
      3'b110:  c = 3'b010;
      3'b100:  c = 3'b011;
      3'b001:  c = 3'b100;
      3'b101:  c = 3'b100;
      3'b010:  c = 3'b101;
      default: c = 3'b110;
    endcase
    return c;
  endfunction

  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.aluop    = alu_class(f3);
        d.memwrite = 1'b1;
        case (f3)
          3'b101:  d.shf = {1'b1, f7b5};
          3'b000:  d.shf = {1'b0, f7b5};
          default: d.shf = 2'b00;
        endcase
      end
      OP_ITYPE: begin
        // ADDI has no subtract form; only SRAI/SRLI look at funct7.
        d.aluop    = alu_class(f3);
        d.alusrc   = 1'b1;
        d.memwrite = 1'b1;
        d.shf      = (f3 == 3'b101) ? {1'b1, f7b5} : 2'b00;
      end
      OP_LOAD, OP_JALR: begin
        d.alusrc   = 1'b1;
        d.memwrite = 1'b1;
      end
      OP_STORE: begin
        d.alusrc = 1'b1;
      end
      OP_BRANCH: begin
        d.branch = 1'b1;
        case (f3)
          3'b000:  d.btype = 3'b000;
          3'b001:  d.btype = 3'b001;
          3'b100:  d.btype = 3'b010;
          3'b101:  d.btype = 3'b011;
          3'b110:  d.btype = 3'b100;
          3'b111:  d.btype = 3'b101;
          default: begin
            d.branch  = 1'b0;
            d.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        d.aluop   = 3'b111;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  dec_t dec_a;
  dec_t dec_b;
  logic unused_f7;

  assign unused_f7 = ^{funct7A[6], funct7A[4:0], funct7B[6], funct7B[4:0]};

  always_comb begin
    dec_a = decode(opcodeA, funct3A, funct7A[5]);
    dec_b = decode(opcodeB, funct3B, funct7B[5]);
  end

  assign ALUOpA      = dec_a.aluop;
  assign ALUOpB      = dec_b.aluop;
  assign ALUSrcA     = dec_a.alusrc;
  assign ALUSrcB     = dec_b.alusrc;
  assign MemWriteA   = dec_a.memwrite;
  assign MemWriteB   = dec_b.memwrite;
  assign BranchA     = dec_a.branch;
  assign BranchB     = dec_b.branch;
  assign BranchTypeA = dec_a.btype;
  assign BranchTypeB = dec_b.btype;

  // Unified mode places lane A's field at the top; split mode packs both lanes at the bottom.
  assign ALUCtrl = mode ? {dec_a.shf, 4'b0000} : {2'b00, dec_b.shf, dec_a.shf};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IllegalSeen <= 1'b0;
    end else if (dec_a.illegal || dec_b.illegal) begin
      IllegalSeen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: hand-derived vector table, sticky-flag sequences, then random
// stimulus against a table-driven reference model.
module tb_control_unit;

  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] F1 = 7'b0100000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcodeA, opcodeB, funct7A, funct7B;
  logic [2:0] funct3A, funct3B;
  logic       mode;
  logic [2:0] ALUOpA, ALUOpB, BranchTypeA, BranchTypeB;
  logic [5:0] ALUCtrl;
  logic       ALUSrcA, ALUSrcB, MemWriteA, MemWriteB, BranchA, BranchB, IllegalSeen;

  int unsigned checks = 0;
  int unsigned errors = 0;

  control_unit dut (
    .clk(clk), .rst(rst),
    .opcodeA(opcodeA), .opcodeB(opcodeB),
    .funct3A(funct3A), .funct3B(funct3B),
    .funct7A(funct7A), .funct7B(funct7B),
    .mode(mode),
    .ALUOpA(ALUOpA), .ALUOpB(ALUOpB), .ALUCtrl(ALUCtrl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .MemWriteA(MemWriteA), .MemWriteB(MemWriteB),
    .BranchA(BranchA), .BranchB(BranchB),
    .BranchTypeA(BranchTypeA), .BranchTypeB(BranchTypeB),
    .IllegalSeen(IllegalSeen)
  );

  always #5 clk = ~clk;

  // {ALUOpA, ALUOpB, ALUCtrl, ALUSrcA, ALUSrcB, MemWriteA, MemWriteB, BranchA, BranchB, BranchTypeA, BranchTypeB}
  logic [23:0] dut_vec;
  assign dut_vec = {ALUOpA, ALUOpB, ALUCtrl, ALUSrcA, ALUSrcB, MemWriteA, MemWriteB,
                    BranchA, BranchB, BranchTypeA, BranchTypeB};

  typedef struct packed {
    logic        mode;
    logic [6:0]  opa;
    logic [2:0]  f3a;
    logic [6:0]  f7a;
    logic [6:0]  opb;
    logic [2:0]  f3b;
    logic [6:0]  f7b;
    logic [23:0] exp;
  } vec_t;

  typedef struct packed {
    logic [2:0] aop;
    logic       src;
    logic       mw;
    logic       br;
    logic [2:0] bt;
    logic [1:0] shf;
    logic       ill;
  } lane_t;

  // Reference tables indexed by funct3; -1 marks an invalid branch condition.
  int alu_tab [8] = '{0, 4, 5, 6, 3, 4, 2, 1};
  int br_tab  [8] = '{0, 1, -1, -1, 2, 3, 4, 5};
  logic [6:0] legal_ops [6] = '{RT, IT, LD, ST, JR, BR};

  function automatic lane_t model_lane(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    lane_t l;
    bit legal, is_alu, right, arith;
    legal  = (op == RT) || (op == IT) || (op == LD) || (op == ST) || (op == JR) || (op == BR);
    is_alu = (op == RT) || (op == IT);
    l.aop  = !legal ? 3'd7 : (is_alu ? 3'(alu_tab[f3]) : 3'd0);
    l.src  = (op == IT) || (op == LD) || (op == ST) || (op == JR);
    l.mw   = (op == RT) || (op == IT) || (op == LD) || (op == JR);
    l.br   = (op == BR) && (br_tab[f3] >= 0);
    l.bt   = l.br ? 3'(br_tab[f3]) : 3'd0;
    right  = is_alu && (f3 == 3'd5);
    arith  = (right || (op == RT && f3 == 3'd0)) && f7[5];
    l.shf  = {right, arith};
    l.ill  = !legal || (op == BR && br_tab[f3] < 0);
    return l;
  endfunction

  function automatic logic [23:0] model_vec(input logic m, input lane_t a, input lane_t b);
    logic [5:0] ctrl;
    ctrl = m ? {a.shf, 4'b0000} : {2'b00, b.shf, a.shf};
    return {a.aop, b.aop, ctrl, a.src, b.src, a.mw, b.mw, a.br, b.br, a.bt, b.bt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [6:0] oa, input logic [2:0] fa, input logic [6:0] sa,
                       input logic [6:0] ob, input logic [2:0] fb, input logic [6:0] sb);
    mode = m;
    opcodeA = oa; funct3A = fa; funct7A = sa;
    opcodeB = ob; funct3B = fb; funct7B = sb;
  endtask

  vec_t  tab [19];
  lane_t la, lb;
  logic  exp_sticky;

  initial begin
    tab[0]  = '{1'b1, RT, 3'b000, F0, IT, 3'b000, F0, {3'b000, 3'b000, 6'b000000, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[1]  = '{1'b1, RT, 3'b000, F1, IT, 3'b000, F0, {3'b000, 3'b000, 6'b010000, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[2]  = '{1'b1, RT, 3'b111, F1, IT, 3'b110, F0, {3'b001, 3'b010, 6'b000000, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[3]  = '{1'b1, RT, 3'b001, F1, IT, 3'b000, F0, {3'b100, 3'b000, 6'b000000, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[4]  = '{1'b1, RT, 3'b101, F0, IT, 3'b000, F0, {3'b100, 3'b000, 6'b100000, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[5]  = '{1'b1, RT, 3'b101, F1, IT, 3'b000, F0, {3'b100, 3'b000, 6'b110000, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[6]  = '{1'b1, BR, 3'b001, F0, RT, 3'b000, F0, {3'b000, 3'b000, 6'b000000, 4'b0001, 2'b10, 3'b001, 3'b000}};
    tab[7]  = '{1'b1, RT, 3'b000, F0, BR, 3'b111, F0, {3'b000, 3'b000, 6'b000000, 4'b0010, 2'b01, 3'b000, 3'b101}};
    tab[8]  = '{1'b0, BR, 3'b100, F0, BR, 3'b000, F0, {3'b000, 3'b000, 6'b000000, 4'b0000, 2'b11, 3'b010, 3'b000}};
    tab[9]  = '{1'b0, RT, 3'b101, F1, RT, 3'b001, F0, {3'b100, 3'b100, 6'b000011, 4'b0011, 2'b00, 3'b000, 3'b000}};
    tab[10] = '{1'b0, RT, 3'b000, F1, IT, 3'b101, F1, {3'b000, 3'b100, 6'b001101, 4'b0111, 2'b00, 3'b000, 3'b000}};
    tab[11] = '{1'b1, ST, 3'b010, F0, LD, 3'b010, F0, {3'b000, 3'b000, 6'b000000, 4'b1101, 2'b00, 3'b000, 3'b000}};
    tab[12] = '{1'b0, JR, 3'b000, F0, IT, 3'b000, F1, {3'b000, 3'b000, 6'b000000, 4'b1111, 2'b00, 3'b000, 3'b000}};
    tab[13] = '{1'b1, IT, 3'b101, F1, ST, 3'b000, F0, {3'b100, 3'b000, 6'b110000, 4'b1110, 2'b00, 3'b000, 3'b000}};
    tab[14] = '{1'b0, 7'h7f, 3'b000, F0, BR, 3'b010, F0, {3'b111, 3'b000, 6'b000000, 4'b0000, 2'b00, 3'b000, 3'b000}};
    tab[15] = '{1'b0, BR, 3'b011, F1, 7'h00, 3'b000, F0, {3'b000, 3'b111, 6'b000000, 4'b0000, 2'b00, 3'b000, 3'b000}};
    tab[16] = '{1'b0, RT, 3'b000, F1, RT, 3'b000, F1, {3'b000, 3'b000, 6'b000101, 4'b0011, 2'b00, 3'b000, 3'b000}};
    tab[17] = '{1'b1, RT, 3'b110, F1, RT, 3'b100, F0, {3'b010, 3'b011, 6'b000000, 4'b0011, 2'b00, 3'b000, 3'b000}};
    tab[18] = '{1'b1, RT, 3'b101, F1, RT, 3'b001, F0, {3'b100, 3'b100, 6'b110000, 4'b0011, 2'b00, 3'b000, 3'b000}};

    // Reset state, and decode stays live while reset is held.
    rst = 1'b1;
    drive(1'b1, RT, 3'b101, F1, IT, 3'b000, F0);
    #2;
    check("rst_sticky", 32'(IllegalSeen), 32'd0);
    check("decode_in_rst", 32'(ALUCtrl), 32'h30);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tab[i].mode, tab[i].opa, tab[i].f3a, tab[i].f7a, tab[i].opb, tab[i].f3b, tab[i].f7b);
      #1;
      check($sformatf("vec%0d", i), 32'(dut_vec), 32'(tab[i].exp));
    end

    // Sticky flag sequences.
    @(negedge clk); rst = 1'b1; drive(1'b0, RT, 3'b000, F0, IT, 3'b000, F0);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    check("legal_no_set", 32'(IllegalSeen), 32'd0);
    @(negedge clk); opcodeB = 7'h7f;
    #1;
    check("ill_before_edge", 32'(IllegalSeen), 32'd0);
    check("ill_aluopb", 32'(ALUOpB), 32'd7);
    check("ill_branchb", 32'(BranchB), 32'd0);
    @(posedge clk); #1;
    check("ill_set", 32'(IllegalSeen), 32'd1);
    @(negedge clk); opcodeB = IT;
    @(posedge clk); #1;
    check("ill_hold", 32'(IllegalSeen), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("async_clear", 32'(IllegalSeen), 32'd0);
    opcodeA = 7'h7f;
    @(posedge clk); #1;
    check("rst_wins", 32'(IllegalSeen), 32'd0);
    @(negedge clk); opcodeA = RT; rst = 1'b0;
    @(negedge clk); opcodeA = BR; funct3A = 3'b010;
    #1;
    check("br010_brancha", 32'(BranchA), 32'd0);
    check("br010_not_yet", 32'(IllegalSeen), 32'd0);
    @(posedge clk); #1;
    check("br010_set", 32'(IllegalSeen), 32'd1);

    // Random stimulus against the reference model.
    @(negedge clk); rst = 1'b1; drive(1'b0, RT, 3'b000, F0, RT, 3'b000, F0);
    #1; rst = 1'b0;
    exp_sticky = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] oa, ob, sa, sb;
      @(negedge clk);
      oa = ($urandom_range(0, 7) < 6) ? legal_ops[$urandom_range(0, 5)] : 7'($urandom);
      ob = ($urandom_range(0, 9) < 9) ? legal_ops[$urandom_range(0, 5)] : 7'($urandom);
      sa = $urandom_range(0, 1) ? F1 : 7'($urandom);
      sb = $urandom_range(0, 1) ? F0 : 7'($urandom);
      drive(1'($urandom), oa, 3'($urandom), sa, ob, 3'($urandom), sb);
      #1;
      la = model_lane(opcodeA, funct3A, funct7A);
      lb = model_lane(opcodeB, funct3B, funct7B);
      check($sformatf("rand%0d", n), 32'(dut_vec), 32'(model_vec(mode, la, lb)));
      @(posedge clk);
      exp_sticky = exp_sticky | la.ill | lb.ill;
      #1;
      check($sformatf("rand_sticky%0d", n), 32'(IllegalSeen), 32'(exp_sticky));
      if (exp_sticky && $urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        #1;
        exp_sticky = 1'b0;
        check($sformatf("rand_clear%0d", n), 32'(IllegalSeen), 32'd0);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
